// File: rtl/scaler_pkg.sv
// Shared widths, default phase table and window indexing for the scaler kernel filter.
package scaler_pkg;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned KERNEL      = 4;
  localparam int unsigned PHASE_W     = 2;
  localparam int unsigned COEF_W      = 10;
  localparam int unsigned COEF_FRAC_W = 8;
  localparam int unsigned COEF_ONE    = 256;
  localparam int unsigned PIPE_DEPTH  = 6;
  localparam int unsigned WIN_W       = PIX_W * KERNEL * KERNEL;
  localparam int unsigned COEF_ADDR_W = 2 * PHASE_W;
  localparam int unsigned COEF_DEPTH  = KERNEL * KERNEL;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Indexed {phase, tap}; each phase sums to COEF_ONE.
  localparam coef_t DEFAULT_COEF [COEF_DEPTH] = '{
    10'sd0, 10'sd256, 10'sd0,   10'sd0,
    10'sd0, 10'sd192, 10'sd64,  10'sd0,
    10'sd0, 10'sd128, 10'sd128, 10'sd0,
    10'sd0, 10'sd64,  10'sd192, 10'sd0
  };

  // LSB position of pixel (row, col) inside a flattened window.
  function automatic int unsigned win_idx(int unsigned row, int unsigned col);
    return PIX_W * (KERNEL * row + col);
  endfunction

endpackage

// File: rtl/scaler_kernel_filter_if.sv
// Window input / pixel output stream bundle between window selection, filter and line writer.
interface scaler_kernel_filter_if
  import scaler_pkg::*;
;
  logic               s_axis_valid;
  logic [WIN_W-1:0]   s_axis_pixel;
  logic [PHASE_W-1:0] s_axis_h;
  logic [PHASE_W-1:0] s_axis_v;
  logic               s_axis_done;
  logic               m_axis_valid;
  logic [PIX_W-1:0]   m_axis_pixel;
  logic               m_axis_done;

  modport slave (
    input  s_axis_valid, s_axis_pixel, s_axis_h, s_axis_v, s_axis_done,
    output m_axis_valid, m_axis_pixel, m_axis_done
  );

  modport master (
    output s_axis_valid, s_axis_pixel, s_axis_h, s_axis_v, s_axis_done,
    input  m_axis_valid, m_axis_pixel, m_axis_done
  );
endinterface

// File: rtl/scaler_coef_table.sv
// 4-phase x 4-tap coefficient register file: reset defaults, one write port, two read ports.
module scaler_coef_table
  import scaler_pkg::*;
(
  input  logic                   core_clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [COEF_ADDR_W-1:0] wr_addr,
  input  coef_t                  wr_data,
  input  logic [PHASE_W-1:0]     h_phase,
  input  logic [PHASE_W-1:0]     v_phase,
  output coef_t                  h_taps [KERNEL],
  output coef_t                  v_taps [KERNEL]
);

  coef_t coef [COEF_DEPTH];

  always_ff @(posedge core_clk) begin
    if (rst) begin
      coef <= DEFAULT_COEF;
    end else if (wr_en) begin
      coef[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int unsigned t = 0; t < KERNEL; t++) begin
      h_taps[t] = coef[{h_phase, t[PHASE_W-1:0]}];
      v_taps[t] = coef[{v_phase, t[PHASE_W-1:0]}];
    end
  end

endmodule

// File: rtl/scaler_kernel_filter.sv
// Separable 4x4 interpolation: horizontal 4-tap per row, then vertical 4-tap; fixed 6-cycle latency.
module scaler_kernel_filter
  import scaler_pkg::*;
#(
  parameter int unsigned PIXEL_BITWIDTH     = PIX_W,
  parameter int unsigned KERNEL_MAX         = KERNEL,
  parameter int unsigned KERNEL_BITWIDTH    = PHASE_W,
  parameter int unsigned COEF_BITWIDTH      = COEF_W,
  parameter int unsigned COEF_FRAC_BITWIDTH = COEF_FRAC_W
) (
  input  logic                           core_clk,
  input  logic                           rst,
  input  logic                           core_arg_filter_en,
  input  logic                           coef_wr_en,
  input  logic [2*KERNEL_BITWIDTH-1:0]   coef_wr_addr,
  input  logic [COEF_BITWIDTH-1:0]       coef_wr_data,
  scaler_kernel_filter_if.slave          axis
);

  localparam int unsigned PROD_W = PIXEL_BITWIDTH + COEF_BITWIDTH;
  localparam int unsigned ROW_W  = PROD_W + 2;
  localparam int unsigned VP_W   = ROW_W + COEF_BITWIDTH;
  localparam int unsigned SUM_W  = VP_W + 2;
  localparam int unsigned SHIFT  = 2 * COEF_FRAC_BITWIDTH;
  localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIXEL_BITWIDTH) - 1);

  coef_t h_taps [KERNEL_MAX];
  coef_t v_taps [KERNEL_MAX];

  scaler_coef_table u_coef_table (
    .core_clk (core_clk),
    .rst      (rst),
    .wr_en    (coef_wr_en),
    .wr_addr  (coef_wr_addr),
    .wr_data  (coef_wr_data),
    .h_phase  (axis.s_axis_h),
    .v_phase  (axis.s_axis_v),
    .h_taps   (h_taps),
    .v_taps   (v_taps)
  );

  logic [PIPE_DEPTH-1:0] vld_sr;
  logic [PIPE_DEPTH-1:0] done_sr;

  logic [KERNEL_MAX-1:0][KERNEL_MAX-1:0][PIXEL_BITWIDTH-1:0] win1;
  coef_t h1 [KERNEL_MAX];
  coef_t v1 [KERNEL_MAX];
  coef_t v2 [KERNEL_MAX];
  coef_t v3 [KERNEL_MAX];
  logic [PIPE_DEPTH-2:0]     en_sr;
  logic [PIXEL_BITWIDTH-1:0] near_sr [PIPE_DEPTH-1];

  logic signed [PROD_W-1:0] prod_d [KERNEL_MAX][KERNEL_MAX];
  logic signed [PROD_W-1:0] prod2  [KERNEL_MAX][KERNEL_MAX];
  logic signed [ROW_W-1:0]  row_d  [KERNEL_MAX];
  logic signed [ROW_W-1:0]  row3   [KERNEL_MAX];
  logic signed [VP_W-1:0]   vp_d   [KERNEL_MAX];
  logic signed [VP_W-1:0]   vp4    [KERNEL_MAX];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum5;
  logic signed [SUM_W-1:0]  shifted;
  logic [PIXEL_BITWIDTH-1:0] filt_d;
  logic [PIXEL_BITWIDTH-1:0] pix_out;

  // Only the valid/done chains reset, so in-flight samples vanish on rst.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      vld_sr  <= '0;
      done_sr <= '0;
      pix_out <= '0;
    end else begin
      vld_sr  <= {vld_sr[PIPE_DEPTH-2:0], axis.s_axis_valid};
      done_sr <= {done_sr[PIPE_DEPTH-2:0], axis.s_axis_done};
      if (vld_sr[PIPE_DEPTH-2]) begin
        pix_out <= en_sr[PIPE_DEPTH-2] ? filt_d : near_sr[PIPE_DEPTH-2];
      end
    end
  end

  // Products and sums are computed modulo the stage width; operands are pre-extended
  // so the truncated result equals the full signed value.
  always_comb begin
    for (int unsigned r = 0; r < KERNEL_MAX; r++) begin
      for (int unsigned c = 0; c < KERNEL_MAX; c++) begin
        prod_d[r][c] = {{(PROD_W-PIXEL_BITWIDTH){1'b0}}, win1[r][c]} *
                       {{(PROD_W-COEF_BITWIDTH){h1[c][COEF_BITWIDTH-1]}}, h1[c]};
      end
    end
    for (int unsigned r = 0; r < KERNEL_MAX; r++) begin
      row_d[r] = '0;
      for (int unsigned c = 0; c < KERNEL_MAX; c++) begin
        row_d[r] = row_d[r] + {{(ROW_W-PROD_W){prod2[r][c][PROD_W-1]}}, prod2[r][c]};
      end
      vp_d[r] = {{(VP_W-ROW_W){row3[r][ROW_W-1]}}, row3[r]} *
                {{(VP_W-COEF_BITWIDTH){v3[r][COEF_BITWIDTH-1]}}, v3[r]};
    end
    sum_d = '0;
    for (int unsigned r = 0; r < KERNEL_MAX; r++) begin
      sum_d = sum_d + {{(SUM_W-VP_W){vp4[r][VP_W-1]}}, vp4[r]};
    end
    shifted = (sum5 + ROUND) >>> SHIFT;
    if (shifted < 0) begin
      filt_d = '0;
    end else if (shifted > PIX_MAX) begin
      filt_d = '1;
    end else begin
      filt_d = shifted[PIXEL_BITWIDTH-1:0];
    end
  end

  always_ff @(posedge core_clk) begin
    win1       <= axis.s_axis_pixel;
    h1         <= h_taps;
    v1         <= v_taps;
    v2         <= v1;
    v3         <= v2;
    en_sr      <= {en_sr[PIPE_DEPTH-3:0], core_arg_filter_en};
    near_sr[0] <= axis.s_axis_pixel[win_idx(1, 1) +: PIXEL_BITWIDTH];
    for (int unsigned i = 1; i < PIPE_DEPTH - 1; i++) begin
      near_sr[i] <= near_sr[i-1];
    end
    prod2 <= prod_d;
    row3  <= row_d;
    vp4   <= vp_d;
    sum5  <= sum_d;
  end

  assign axis.m_axis_valid = vld_sr[PIPE_DEPTH-1];
  assign axis.m_axis_done  = done_sr[PIPE_DEPTH-1];
  assign axis.m_axis_pixel = pix_out;

endmodule

// File: tb/tb_scaler_kernel_filter.sv
// Directed scoreboard bench for scaler_kernel_filter: value, latency, done timing, mode and reset.
module tb_scaler_kernel_filter;
  import scaler_pkg::*;

  logic       core_clk = 1'b0;
  logic       rst = 1'b1;
  logic       filter_en = 1'b1;
  logic       coef_wr_en = 1'b0;
  logic [3:0] coef_wr_addr = '0;
  logic [9:0] coef_wr_data = '0;

  scaler_kernel_filter_if bus ();

  scaler_kernel_filter dut (
    .core_clk           (core_clk),
    .rst                (rst),
    .core_arg_filter_en (filter_en),
    .coef_wr_en         (coef_wr_en),
    .coef_wr_addr       (coef_wr_addr),
    .coef_wr_data       (coef_wr_data),
    .axis               (bus)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int pix;
    int due;
  } exp_t;

  exp_t exp_q [$];
  int   done_q [$];
  int   tb_coef [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int model(input logic [127:0] w, input int h, input int v, input bit fe);
    int acc;
    int rs;
    int px;
    int res;
    if (!fe) return int'(w[40 +: 8]);
    acc = 0;
    for (int r = 0; r < 4; r++) begin
      rs = 0;
      for (int c = 0; c < 4; c++) begin
        px = int'(w[8*(4*r+c) +: 8]);
        rs += px * tb_coef[h*4+c];
      end
      acc += rs * tb_coef[v*4+r];
    end
    res = (acc + 32768) >>> 16;
    if (res < 0) res = 0;
    if (res > 255) res = 255;
    return res;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] p);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = p;
    return w;
  endfunction

  function automatic logic [127:0] rows(input logic [7:0] c0, input logic [7:0] c1,
                                        input logic [7:0] c2, input logic [7:0] c3);
    logic [127:0] w;
    for (int r = 0; r < 4; r++) w[32*r +: 32] = {c3, c2, c1, c0};
    return w;
  endfunction

  function automatic logic [127:0] rnd_win();
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'($urandom);
    return w;
  endfunction

  always @(negedge core_clk) begin
    exp_t e;
    int   d;
    if (bus.m_axis_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", bus.m_axis_pixel, e.pix);
        chk("valid_cycle", cyc, e.due);
      end
    end
    if (bus.m_axis_done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
      end
    end
  end

  task automatic drive(input logic [127:0] w, input int h, input int v, input bit fe);
    @(posedge core_clk); #1;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_pixel = w;
    bus.s_axis_h     = 2'(h);
    bus.s_axis_v     = 2'(v);
    bus.s_axis_done  = 1'b0;
    filter_en        = fe;
  endtask

  task automatic send(input logic [127:0] w, input int h, input int v, input bit fe, input int expv);
    drive(w, h, v, fe);
    exp_q.push_back('{expv, cyc + 6});
  endtask

  task automatic send_m(input logic [127:0] w, input int h, input int v, input bit fe);
    send(w, h, v, fe, model(w, h, v, fe));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge core_clk); #1;
      bus.s_axis_valid = 1'b0;
      bus.s_axis_done  = 1'b0;
    end
  endtask

  task automatic line_done();
    @(posedge core_clk); #1;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_done  = 1'b1;
    done_q.push_back(cyc + 6);
  endtask

  task automatic wr_coef(input int addr, input int data);
    @(posedge core_clk); #1;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_done  = 1'b0;
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'(addr);
    coef_wr_data = 10'(data);
    tb_coef[addr] = data;
    @(posedge core_clk); #1;
    coef_wr_en = 1'b0;
  endtask

  initial begin
    logic [127:0] w;
    for (int p = 0; p < 4; p++) begin
      tb_coef[p*4+0] = 0;
      tb_coef[p*4+1] = 256 - 64 * p;
      tb_coef[p*4+2] = 64 * p;
      tb_coef[p*4+3] = 0;
    end
    bus.s_axis_valid = 1'b0;
    bus.s_axis_pixel = '0;
    bus.s_axis_h     = '0;
    bus.s_axis_v     = '0;
    bus.s_axis_done  = 1'b0;

    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_valid", bus.m_axis_valid, 0);
    chk("rst_done", bus.m_axis_done, 0);
    chk("rst_pixel", bus.m_axis_pixel, 0);
    rst = 1'b0;

    // Flat window, identity phase
    send(fill(8'd100), 0, 0, 1'b1, 100);
    idle(8);

    // Horizontal phases and rounding
    send(rows(8'd0, 8'd40, 8'd80, 8'd120), 2, 0, 1'b1, 60);
    send(rows(8'd0, 8'd40, 8'd80, 8'd120), 1, 0, 1'b1, 50);
    send(rows(8'd0, 8'd1, 8'd2, 8'd0), 2, 0, 1'b1, 2);
    idle(8);

    // Clamping with an overshooting phase 0
    wr_coef(1, 384);
    wr_coef(2, -128);
    send(rows(8'd0, 8'd255, 8'd0, 8'd0), 0, 0, 1'b1, 255);
    send(rows(8'd0, 8'd0, 8'd255, 8'd0), 0, 0, 1'b1, 0);
    idle(8);
    wr_coef(1, 256);
    wr_coef(2, 0);

    // Back-to-back line of five windows, then line end
    for (int i = 0; i < 5; i++) send_m(rnd_win(), int'($urandom_range(3)), int'($urandom_range(3)), 1'b1);
    line_done();
    idle(10);

    // Nearest mode
    w = '0;
    w[40 +: 8] = 8'd77;
    send(w, 2, 1, 1'b0, 77);
    idle(8);

    // Mode toggles every sample
    for (int i = 0; i < 8; i++) send_m(rnd_win(), int'($urandom_range(3)), int'($urandom_range(3)), (i % 2) == 0);
    idle(8);

    // Mid-line reset: corrupt phase 3 first, and write again while rst is high
    wr_coef(13, 0);
    drive(fill(8'd100), 3, 3, 1'b1);
    drive(fill(8'd100), 3, 3, 1'b1);
    idle(2);
    @(posedge core_clk); #1;
    bus.s_axis_valid = 1'b0;
    rst          = 1'b1;
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'd13;
    coef_wr_data = 10'd5;
    @(posedge core_clk); #1;
    coef_wr_en = 1'b0;
    @(posedge core_clk); #1;
    rst = 1'b0;
    tb_coef[13] = 64;
    idle(10);
    chk("post_rst_valid", bus.m_axis_valid, 0);
    send(fill(8'd100), 3, 3, 1'b1, 100);
    idle(10);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
